alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

- Execute-stage ALU for the RISC-V core.
- Consumes the 4-bit `operation` code produced by the ALU control decoder, plus the two operand values, and returns a registered result and zero flag over a valid/ready handshake.
- Single-cycle ops (AND, OR, ADD, SUB, LUI pass-through) complete in one cycle.
- Shift-left-logical runs on a serial one-bit-per-cycle shifter, so the block is multi-cycle and backpressures the pipeline through `in_ready`.

## Interface
- `WIDTH`, default 32: operand/result width; must be a power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): shift-amount width, derived; do not override.

- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: operation/operands valid.
- `in_ready`  out  1: block can accept; high only in IDLE.
- `operation`  in  4: ALU control code.
- `src_a`  in  WIDTH: operand A.
- `src_b`  in  WIDTH: operand B; `src_b[SHW-1:0]` is the shift amount for SLL.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `result`  out  WIDTH: registered result.
- `zero`  out  1: registered, (result == 0); used for branch decisions.
- `illegal`  out  1: registered; the accepted operation code was unsupported.

## Operation
- Accept occurs when `in_valid && in_ready` at a rising edge; operands are captured at that edge and may change afterwards.
- Operation codes:
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b, mod 2^WIDTH, carry discarded.
  - 0110 SUB: a − b, two's complement, mod 2^WIDTH.
  - 1000 LUI: result = b.
  - 0011 SLL: a << b[SHW-1:0]; upper bits of b are ignored.
  - Any other code: result = 0, `illegal` = 1, zero = 1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE → DONE on accept of any non-SLL op (result, zero and illegal written at the accept edge).
- IDLE → DONE on accept of SLL with shamt n = 0 (result = a) or n = 1 (result = a<<1).
- IDLE → SHIFT on accept of SLL with n ≥ 2:
  - At the accept edge: acc = a<<1, cnt = n−1.
  - Each SHIFT edge: acc <<= 1, cnt −= 1.
  - When cnt == 1 at an edge: that edge performs the final shift, writes result/zero, and moves to DONE.
- DONE → IDLE when `out_ready` is high at an edge. No accept occurs in DONE.
- `in_ready` = (state == IDLE); `out_valid` = (state == DONE). Both are pure state decodes.
- `illegal` is cleared on every legal accept.

## Timing
- Reset (async, any state) forces:
  - state = IDLE, so `in_ready` = 1 and `out_valid` = 0.
  - result = 0, zero = 0, illegal = 0, acc = 0, cnt = 0.
  - An in-flight shift is aborted; no output is produced for it.
- Latency, counted as edges from the accept edge to the first cycle `out_valid` is high:
  - 1 for non-SLL ops and for SLL with n ≤ 1.
  - n for SLL with n ≥ 2. Maximum is WIDTH−1 (31 at default).
- Throughput: at most one op per (latency + 1) cycles; IDLE always lasts ≥ 1 cycle between results.
- While `out_valid && !out_ready`: result, zero and illegal hold stable; `in_ready` stays low.
- The consumer may hold `out_ready` high permanently; DONE then lasts exactly 1 cycle.
- `in_valid` while `in_ready` = 0 is ignored; the producer must hold its request until accepted.
- Rising `rst` in the same cycle as an accept: reset wins and the op is dropped.

## Test plan
- Reset release, then ADD a=0xFFFF_FFFF, b=0x0000_0001 with `out_ready`=1 → `out_valid` 1 cycle after accept; result = 0, zero = 1, illegal = 0.
- SUB a=5, b=7 → result = 0xFFFF_FFFE, zero = 0. Then AND 0xF0F0_F0F0 & 0x0FF0_0FF0 → 0x00F0_00F0. OR of the same operands → 0xFFF0_FFF0. LUI b=0x12345000 → 0x12345000.
- SLL a=0x0000_0001 with b=0, 1, 2, 31, 0xFFFF_FFE5 → results 0x1, 0x2, 0x4, 0x8000_0000, 0x20 (shamt 5). Latencies must be 1, 1, 2, 31, 5 cycles; `in_ready` = 0 throughout each shift.
- Backpressure: ADD 3+4 with `out_ready`=0 for 10 cycles → result = 7 held stable, `out_valid` = 1, `in_ready` = 0. A new request presented meanwhile is not accepted until one cycle after `out_ready` rises.
- Illegal code 4'b1111 → result = 0, zero = 1, illegal = 1, latency 1. The following ADD clears `illegal`.
- Assert `rst` mid-SLL (n=20, at cycle 7 of the shift) → the next cycle shows `out_valid`=0 and `in_ready`=1 with result/zero/illegal = 0. A new SLL with n=3 then completes correctly in 3 cycles.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered result/zero/illegal over a valid/ready handshake.
// SLL uses a serial one-bit-per-cycle shifter; every other op completes in one cycle.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b1000;

  localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic             zero_r, zero_s;
  logic             illegal_r, illegal_s;
  logic [SHW-1:0]   cnt_r, cnt_s;
  logic [SHW-1:0]   shamt_s;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_LUI, OP_SLL: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  endfunction

  // Unsupported codes deliberately produce zero so the branch flag reads as taken-safe.
  function automatic logic [WIDTH-1:0] single_cycle_op(input logic [3:0]       op,
                                                       input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  single_cycle_op = a & b;
      OP_OR:   single_cycle_op = a | b;
      OP_ADD:  single_cycle_op = a + b;
      OP_SUB:  single_cycle_op = a - b;
      OP_LUI:  single_cycle_op = b;
      default: single_cycle_op = ZERO_W;
    endcase
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign result    = result_r;
  assign zero      = zero_r;
  assign illegal   = illegal_r;
  assign shamt_s   = src_b[SHW-1:0];

  // Next-state and datapath update logic.
  always_comb begin
    state_s   = state_r;
    result_s  = result_r;
    zero_s    = zero_r;
    illegal_s = illegal_r;
    acc_s     = acc_r;
    cnt_s     = cnt_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          illegal_s = !op_legal(operation);
          if ((operation == OP_SLL) && (shamt_s > CNT_ONE)) begin
            // First shift happens at the accept edge, so cnt holds the remaining shifts.
            acc_s   = src_a << 1'b1;
            cnt_s   = shamt_s - CNT_ONE;
            state_s = SHIFT;
          end else if (operation == OP_SLL) begin
            result_s = (shamt_s == CNT_ONE) ? (src_a << 1'b1) : src_a;
            zero_s   = (result_s == ZERO_W);
            state_s  = DONE;
          end else begin
            result_s = single_cycle_op(operation, src_a, src_b);
            zero_s   = (result_s == ZERO_W);
            state_s  = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        acc_s = acc_r << 1'b1;
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          result_s = acc_r << 1'b1;
          zero_s   = (result_s == ZERO_W);
          state_s  = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      result_r  <= ZERO_W;
      zero_r    <= 1'b0;
      illegal_r <= 1'b0;
      acc_r     <= ZERO_W;
      cnt_r     <= CNT_ZERO;
    end else begin
      state_r   <= state_s;
      result_r  <= result_s;
      zero_r    <= zero_s;
      illegal_r <= illegal_s;
      acc_r     <= acc_s;
      cnt_r     <= cnt_s;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: scoreboard of expected results per accepted op.
module tb_alu_exec_unit;
  localparam int W = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b1000;
  localparam logic [3:0] OP_BAD = 4'b1111;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   operation;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
    int           lat;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] obs_res;
  logic         obs_zero;
  logic         obs_ill;
  logic         obs_valid;
  logic         obs_rdy_bad;
  int           obs_lat;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic exp_t mk_exp(input string name, input logic [W-1:0] res,
                                  input logic ill, input int lat);
    exp_t e;
    e.name = name;
    e.res  = res;
    e.zero = (res == 32'h0000_0000);
    e.ill  = ill;
    e.lat  = lat;
    return e;
  endfunction

  // Push expectation, accept one op, then wait (bounded) for out_valid and capture outputs.
  task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res,
                       input logic exp_ill, input int exp_lat);
    sb.push_back(mk_exp(name, exp_res, exp_ill, exp_lat));
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    operation = 4'b0000;
    src_a     = ~a;
    src_b     = ~b;
    obs_lat     = 1;
    obs_rdy_bad = 1'b0;
    while (!out_valid && obs_lat < 200) begin
      if (in_ready) obs_rdy_bad = 1'b1;
      @(posedge clk); #1;
      obs_lat++;
    end
    obs_valid = out_valid;
    obs_res   = result;
    obs_zero  = zero;
    obs_ill   = illegal;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    operation = 4'b0000; src_a = 32'h0; src_b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({in_ready, out_valid, result, zero, illegal} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got in_ready=%b out_valid=%b result=%h zero=%b illegal=%b, expected 1 0 00000000 0 0",
               in_ready, out_valid, result, zero, illegal);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [3:0] ops [6] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LUI, OP_ADD};
    logic [W-1:0] as [6] = '{32'hFFFF_FFFF, 32'd5, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hDEAD_BEEF, 32'h1234_0000};
    logic [W-1:0] bs [6] = '{32'h0000_0001, 32'd7, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h1234_5000, 32'h0000_5678};
    logic [W-1:0] rs [6] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h00F0_00F0, 32'hFFF0_FFF0, 32'h1234_5000, 32'h1234_5678};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue($sformatf("arith%0d", i), ops[i], as[i], bs[i], rs[i], 1'b0, 1);
      e = sb.pop_front();
      n_tests++;
      if (!obs_valid || obs_res !== e.res || obs_zero !== e.zero || obs_ill !== e.ill || obs_lat != e.lat) begin
        n_fail++;
        $display("FAIL %s: got valid=%b result=%h zero=%b illegal=%b lat=%0d, expected result=%h zero=%b illegal=%b lat=%0d",
                 e.name, obs_valid, obs_res, obs_zero, obs_ill, obs_lat, e.res, e.zero, e.ill, e.lat);
      end
    end
  endtask

  task automatic test_sll();
    logic [W-1:0] bs [5] = '{32'd0, 32'd1, 32'd2, 32'd31, 32'hFFFF_FFE5};
    logic [W-1:0] rs [5] = '{32'h1, 32'h2, 32'h4, 32'h8000_0000, 32'h20};
    int           ls [5] = '{1, 1, 2, 31, 5};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue($sformatf("sll%0d", i), OP_SLL, 32'h0000_0001, bs[i], rs[i], 1'b0, ls[i]);
      e = sb.pop_front();
      n_tests++;
      if (!obs_valid || obs_res !== e.res || obs_zero !== e.zero || obs_ill !== e.ill || obs_lat != e.lat) begin
        n_fail++;
        $display("FAIL %s: got valid=%b result=%h zero=%b illegal=%b lat=%0d, expected result=%h zero=%b illegal=%b lat=%0d",
                 e.name, obs_valid, obs_res, obs_zero, obs_ill, obs_lat, e.res, e.zero, e.ill, e.lat);
      end
      n_tests++;
      if (obs_rdy_bad !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_in_ready: got in_ready=1 during shift, expected 0", e.name);
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    issue("illegal", OP_BAD, 32'h1234_5678, 32'h0000_5678, 32'h0, 1'b1, 1);
    e = sb.pop_front();
    n_tests++;
    if (!obs_valid || obs_res !== e.res || obs_zero !== e.zero || obs_ill !== e.ill || obs_lat != e.lat) begin
      n_fail++;
      $display("FAIL %s: got valid=%b result=%h zero=%b illegal=%b lat=%0d, expected result=%h zero=%b illegal=%b lat=%0d",
               e.name, obs_valid, obs_res, obs_zero, obs_ill, obs_lat, e.res, e.zero, e.ill, e.lat);
    end
    issue("illegal_clear", OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1);
    e = sb.pop_front();
    n_tests++;
    if (!obs_valid || obs_res !== e.res || obs_zero !== e.zero || obs_ill !== e.ill || obs_lat != e.lat) begin
      n_fail++;
      $display("FAIL %s: got valid=%b result=%h zero=%b illegal=%b lat=%0d, expected result=%h zero=%b illegal=%b lat=%0d",
               e.name, obs_valid, obs_res, obs_zero, obs_ill, obs_lat, e.res, e.zero, e.ill, e.lat);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    issue("bp_add", OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1);
    e = sb.pop_front();
    n_tests++;
    if (!obs_valid || obs_res !== e.res || obs_zero !== e.zero || obs_lat != e.lat) begin
      n_fail++;
      $display("FAIL %s: got valid=%b result=%h zero=%b lat=%0d, expected result=%h zero=%b lat=%0d",
               e.name, obs_valid, obs_res, obs_zero, obs_lat, e.res, e.zero, e.lat);
    end
    sb.push_back(mk_exp("bp_pending_or", 32'h3, 1'b0, 1));
    operation = OP_OR; src_a = 32'd1; src_b = 32'd2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (result !== 32'd7 || zero !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got result=%h zero=%b out_valid=%b in_ready=%b, expected 00000007 0 1 0",
                 i, result, zero, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (out_valid !== 1'b1 || result !== e.res || zero !== e.zero || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got out_valid=%b result=%h zero=%b in_ready=%b, expected 1 %h %b 0",
               e.name, out_valid, result, zero, in_ready, e.res, e.zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    exp_t e;
    operation = OP_SLL; src_a = 32'h1; src_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'h3) begin
      n_fail++;
      $display("FAIL mid_shift: got out_valid=%b in_ready=%b result=%h, expected 0 0 00000003",
               out_valid, in_ready, result);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({out_valid, in_ready, result, zero, illegal} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_shift: got out_valid=%b in_ready=%b result=%h zero=%b illegal=%b, expected 0 1 00000000 0 0",
               out_valid, in_ready, result, zero, illegal);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    issue("sll_after_rst", OP_SLL, 32'h1, 32'd3, 32'h8, 1'b0, 3);
    e = sb.pop_front();
    n_tests++;
    if (!obs_valid || obs_res !== e.res || obs_zero !== e.zero || obs_ill !== e.ill || obs_lat != e.lat) begin
      n_fail++;
      $display("FAIL %s: got valid=%b result=%h zero=%b illegal=%b lat=%0d, expected result=%h zero=%b illegal=%b lat=%0d",
               e.name, obs_valid, obs_res, obs_zero, obs_ill, obs_lat, e.res, e.zero, e.ill, e.lat);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_sll();
    test_illegal();
    test_backpressure();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
